// File: rtl/mips_iter_divider_if.sv
// Handshake and operand/result bundle between the pipeline (master) and the
// iterative divider (slave).
interface mips_iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/mips_iter_divider.sv
// Restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, with sign
// handling done on magnitudes before and after the iteration loop.
module mips_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_iter_divider_if.slave  dif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic             op_signed;
    logic [WIDTH-1:0] a_raw, b_raw;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] q_out, r_out;
    logic             dbz;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Two's complement negation modulo 2^WIDTH when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign accept  = dif.start && (state == IDLE || state == DONE);
    // Bit WIDTH of trial is the borrow: rem < dvs keeps the true difference below 2^WIDTH.
    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (count == CW'(WIDTH - 1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = accept ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dif.busy = 1'b0;
        dif.done = 1'b0;
        case (state)
            PREP, ITER, FIXUP: dif.busy = 1'b1;
            DONE:              dif.done = 1'b1;
            default:           ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_signed <= 1'b0;
            a_raw     <= '0;
            b_raw     <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            count     <= '0;
            q_out     <= '0;
            r_out     <= '0;
            dbz       <= 1'b0;
        end else begin
            if (accept) begin
                op_signed <= dif.signed_op;
                a_raw     <= dif.dividend;
                b_raw     <= dif.divisor;
            end
            case (state)
                PREP: begin
                    dvd   <= cond_neg(a_raw, op_signed & a_raw[WIDTH-1]);
                    dvs   <= cond_neg(b_raw, op_signed & b_raw[WIDTH-1]);
                    q_neg <= op_signed & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    r_neg <= op_signed & a_raw[WIDTH-1];
                    rem   <= '0;
                    count <= '0;
                end
                ITER: begin
                    count <= count + CW'(1);
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                end
                FIXUP: begin
                    // Divide by zero reports the untouched dividend, bypassing sign fixup.
                    if (b_raw == '0) begin
                        q_out <= '1;
                        r_out <= a_raw;
                        dbz   <= 1'b1;
                    end else begin
                        q_out <= cond_neg(dvd, q_neg);
                        r_out <= cond_neg(rem, r_neg);
                        dbz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dif.quotient    = q_out;
    assign dif.remainder   = r_out;
    assign dif.div_by_zero = dbz;
endmodule

// File: tb/tb_mips_iter_divider.sv
// Directed and random checks of the iterative divider against an arithmetic
// reference model of DIV/DIVU semantics.
module tb_mips_iter_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mips_iter_divider_if #(.WIDTH(32)) dif();

    mips_iter_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            z = 1'b0;
            if (sop) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sop, input logic [31:0] a, input logic [31:0] b);
        dif.start     = 1'b1;
        dif.signed_op = sop;
        dif.dividend  = a;
        dif.divisor   = b;
    endtask

    // Called with start already driven; the next rising edge is E0.
    // Returns just after E34, with the divider in its done cycle.
    task automatic run_check(input logic sop, input logic [31:0] a, input logic [31:0] b,
                             input string tag, input int poke_at);
        logic [31:0] eq, er;
        logic        ez;
        logic        win_ok;
        model(sop, a, b, eq, er, ez);
        @(posedge clk); #1;
        dif.start = 1'b0;
        win_ok = 1'b1;
        for (int k = 0; k < 34; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (dif.busy !== 1'b1 || dif.done !== 1'b0) win_ok = 1'b0;
            if (k == poke_at) begin
                dif.start     = 1'b1;
                dif.signed_op = ~sop;
                dif.dividend  = $urandom;
                dif.divisor   = $urandom;
            end else if (k == poke_at + 1) begin
                dif.start = 1'b0;
            end
        end
        check({tag, "_busywin"}, {31'd0, win_ok}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_done"}, {30'd0, dif.busy, dif.done}, 32'd1);
        check({tag, "_q"}, dif.quotient, eq);
        check({tag, "_r"}, dif.remainder, er);
        check({tag, "_dbz"}, {31'd0, dif.div_by_zero}, {31'd0, ez});
    endtask

    task automatic op(input logic sop, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        launch(sop, a, b);
        run_check(sop, a, b, tag, -1);
    endtask

    initial begin
        logic [31:0] hq, hr;
        logic        nodone;
        logic [31:0] ra, rb;
        logic        rs;

        rst_n = 1'b0;
        dif.start = 1'b0; dif.signed_op = 1'b0; dif.dividend = '0; dif.divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        check("rst_q", dif.quotient, 32'd0);
        check("rst_r", dif.remainder, 32'd0);
        check("rst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        op(1'b0, 32'd100, 32'd7, "divu_100_7");
        check("divu_100_7_qconst", dif.quotient, 32'h0000_000E);
        check("divu_100_7_rconst", dif.remainder, 32'h0000_0002);
        hq = dif.quotient; hr = dif.remainder;
        @(posedge clk); #1;
        check("done_pulse_len", {31'd0, dif.done}, 32'd0);
        check("hold_q", dif.quotient, hq);
        check("hold_r", dif.remainder, hr);

        op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
        check("div_m7_2_qconst", dif.quotient, 32'hFFFF_FFFD);
        check("div_m7_2_rconst", dif.remainder, 32'hFFFF_FFFF);
        op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, "div_7_m2");
        check("div_7_m2_rconst", dif.remainder, 32'h0000_0001);
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_qconst", dif.quotient, 32'h8000_0000);
        op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        check("divu_big_rconst", dif.remainder, 32'h8000_0000);
        op(1'b0, 32'd5, 32'd0, "divu_5_0");
        op(1'b1, 32'hFFFF_FFF0, 32'd0, "div_m16_0");
        check("div_m16_0_rconst", dif.remainder, 32'hFFFF_FFF0);

        // Start issued mid-operation must be ignored.
        @(negedge clk);
        launch(1'b0, 32'd1000, 32'd9);
        run_check(1'b0, 32'd1000, 32'd9, "ignore_busy_start", 4);

        // Start held during the done cycle chains a new operation.
        launch(1'b1, 32'hFFFF_FC00, 32'd7);
        run_check(1'b1, 32'hFFFF_FC00, 32'd7, "b2b_second", -1);
        launch(1'b0, 32'd12345, 32'd100);
        run_check(1'b0, 32'd12345, 32'd100, "b2b_third", -1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        launch(1'b0, 32'd77777, 32'd13);
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, dif.busy}, 32'd0);
        check("midrst_done", {31'd0, dif.done}, 32'd0);
        check("midrst_q", dif.quotient, 32'd0);
        check("midrst_r", dif.remainder, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        nodone = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) nodone = 1'b0;
        end
        check("midrst_no_done", {31'd0, nodone}, 32'd1);
        op(1'b0, 32'd9, 32'd3, "after_rst");

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 300);
                2:       rb = -32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            op(rs, ra, rb, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
